// File: rtl/cpu_dia11.sv
// cpu_dia11: 8-bit accumulator CPU, 4-bit PC, 4-bit data address space.
// One instruction every three clocks: FETCH -> DECODE -> EXECUTE.
//
// Optional feature macro: CPU_HALT_INSTR_EN
//   defined   : opcode F enters a HALT state that only reset leaves.
//   undefined : opcode F executes as a NOP and no HALT state exists.
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous, active-low reset
//   instMemAddrBus    out  instruction ROM address (= PC)
//   instMemDataBus    in   instruction from combinational ROM
//   dataMemAddrBus    out  data memory address (= IR[3:0])
//   dataMemInDataBus  in   data memory read data (combinational)
//   dataMemOutDataBus out  data memory write data (= ACC)
//   mReadFlag         out  data memory read strobe (DECODE/EXECUTE of reads)
//   mWriteFlag        out  data memory write strobe (EXECUTE of STA)
//   accOut            out  accumulator
//   aluOut            out  combinational ALU result
//   opcode            out  IR[7:4]
module cpu_dia11 #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] instMemAddrBus,
  input  logic [7:0] instMemDataBus,
  output logic [3:0] dataMemAddrBus,
  input  logic [7:0] dataMemInDataBus,
  output logic [7:0] dataMemOutDataBus,
  output logic       mReadFlag,
  output logic       mWriteFlag,
  output logic [7:0] accOut,
  output logic [7:0] aluOut,
  output logic [3:0] opcode
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLda  = 4'h1;
  localparam logic [3:0] OpSta  = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;
  localparam logic [3:0] OpLdi  = 4'h8;
  localparam logic [3:0] OpAddi = 4'h9;
  localparam logic [3:0] OpNot  = 4'hA;
  localparam logic [3:0] OpShl  = 4'hB;
  localparam logic [3:0] OpShr  = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpJz   = 4'hE;
`ifdef CPU_HALT_INSTR_EN
  localparam logic [3:0] OpHlt  = 4'hF;
`endif

`ifdef CPU_HALT_INSTR_EN
  typedef enum logic [1:0] {StFetch, StDecode, StExecute, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StDecode, StExecute} state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  ir_q, ir_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  alu;
  logic [3:0]  op;
  logic [3:0]  arg;

  assign op  = ir_q[7:4];
  assign arg = ir_q[3:0];

  // Opcodes that read data memory: LDA and the memory-operand ALU ops.
  function automatic logic is_read(input logic [3:0] o);
    return (o == OpLda) || ((o >= OpAdd) && (o <= OpXor));
  endfunction

  function automatic logic writes_acc(input logic [3:0] o);
    return (o == OpLda) || ((o >= OpAdd) && (o <= OpShr));
  endfunction

  // Non-ALU opcodes pass ACC through so aluOut is always meaningful.
  always_comb begin
    alu = acc_q;
    case (op)
      OpLda:   alu = dataMemInDataBus;
      OpAdd:   alu = acc_q + dataMemInDataBus;
      OpSub:   alu = acc_q - dataMemInDataBus;
      OpAnd:   alu = acc_q & dataMemInDataBus;
      OpOr:    alu = acc_q | dataMemInDataBus;
      OpXor:   alu = acc_q ^ dataMemInDataBus;
      OpLdi:   alu = {4'b0000, arg};
      OpAddi:  alu = acc_q + {4'b0000, arg};
      OpNot:   alu = ~acc_q;
      OpShl:   alu = {acc_q[6:0], 1'b0};
      OpShr:   alu = {1'b0, acc_q[7:1]};
      default: alu = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_d    = instMemDataBus;
        // Strobe is registered, so it is decided from the incoming instruction.
        rd_d    = is_read(instMemDataBus[7:4]);
        state_d = StDecode;
      end
      StDecode: begin
        rd_d    = rd_q;
        wr_d    = (op == OpSta);
        state_d = StExecute;
      end
      StExecute: begin
        if (writes_acc(op)) begin
          acc_d = alu;
        end
        if ((op == OpJmp) || ((op == OpJz) && (acc_q == 8'h00))) begin
          pc_d = arg;
        end else begin
          pc_d = pc_q + 4'd1;
        end
        state_d = StFetch;
`ifdef CPU_HALT_INSTR_EN
        // HLT freezes PC at its own address.
        if (op == OpHlt) begin
          pc_d    = pc_q;
          state_d = StHalt;
        end
`endif
      end
`ifdef CPU_HALT_INSTR_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      acc_q   <= 8'h00;
      ir_q    <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign instMemAddrBus    = pc_q;
  assign dataMemAddrBus    = arg;
  assign dataMemOutDataBus = acc_q;
  assign mReadFlag         = rd_q;
  assign mWriteFlag        = wr_q;
  assign accOut            = acc_q;
  assign aluOut            = alu;
  assign opcode            = op;

endmodule

// File: tb/tb_cpu_dia11.sv
module tb_cpu_dia11;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] instMemAddrBus;
  logic [7:0] instMemDataBus;
  logic [3:0] dataMemAddrBus;
  logic [7:0] dataMemInDataBus;
  logic [7:0] dataMemOutDataBus;
  logic       mReadFlag;
  logic       mWriteFlag;
  logic [7:0] accOut;
  logic [7:0] aluOut;
  logic [3:0] opcode;

  logic [7:0] rom  [16];
  logic [7:0] dmem [16];

  int errors = 0;
  int checks = 0;

  cpu_dia11 #(.RESET_PC(4'h0)) dut (
    .clock             (clock),
    .reset             (reset),
    .instMemAddrBus    (instMemAddrBus),
    .instMemDataBus    (instMemDataBus),
    .dataMemAddrBus    (dataMemAddrBus),
    .dataMemInDataBus  (dataMemInDataBus),
    .dataMemOutDataBus (dataMemOutDataBus),
    .mReadFlag         (mReadFlag),
    .mWriteFlag        (mWriteFlag),
    .accOut            (accOut),
    .aluOut            (aluOut),
    .opcode            (opcode)
  );

  always #5 clock = ~clock;

  assign instMemDataBus   = rom[instMemAddrBus];
  assign dataMemInDataBus = dmem[dataMemAddrBus];

  typedef struct {
    string      name;
    logic [63:0] prog;  // bytes for ROM addresses 0..7, address 0 in the top byte
    logic [7:0] last;   // byte at ROM address 15
    int         n;      // instructions to run
    logic [7:0] acc;
    logic [3:0] pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic [63:0] p, logic [7:0] l, int n,
                              logic [7:0] acc, logic [3:0] pc);
    vec_t v;
    v.name = nm; v.prog = p; v.last = l; v.n = n; v.acc = acc; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: a write strobe seen before the edge commits at that edge.
  task automatic tick();
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    w = mWriteFlag; a = dataMemAddrBus; d = dataMemOutDataBus;
    @(posedge clock);
    if (w === 1'b1) dmem[a] = d;
    #1;
  endtask

  task automatic start(input logic [63:0] prog, input logic [7:0] last);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 8'h00;
      dmem[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) rom[i] = prog[63-8*i -: 8];
    rom[15] = last;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Instruction-level reference model.
  logic [3:0] mpc;
  logic [7:0] macc;
  logic [7:0] mmem [16];

  task automatic run_random(input int n_instr);
    logic [7:0] ins;
    logic [3:0] op, a;
    logic       rd, wr;
    logic [5:0] s;
    logic [7:0] alu_seen;
    logic [3:0] opc_seen;
    start(64'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'($urandom);
`ifdef CPU_HALT_INSTR_EN
      if (rom[i][7:4] == 4'hF) rom[i] = 8'h00;
`endif
      dmem[i] = 8'($urandom);
      mmem[i] = dmem[i];
    end
    mpc = 4'h0;
    macc = 8'h00;
    for (int k = 0; k < n_instr; k++) begin
      ins = rom[mpc];
      op = ins[7:4];
      a  = ins[3:0];
      rd = (op == 4'h1) || (op >= 4'h3 && op <= 4'h7);
      wr = (op == 4'h2);
      case (op)
        4'h1: macc = mmem[a];
        4'h2: mmem[a] = macc;
        4'h3: macc = macc + mmem[a];
        4'h4: macc = macc - mmem[a];
        4'h5: macc = macc & mmem[a];
        4'h6: macc = macc | mmem[a];
        4'h7: macc = macc ^ mmem[a];
        4'h8: macc = {4'h0, a};
        4'h9: macc = macc + {4'h0, a};
        4'hA: macc = ~macc;
        4'hB: macc = macc * 2;
        4'hC: macc = macc / 2;
        default: ;
      endcase
      if (op == 4'hD || (op == 4'hE && macc == 8'h00)) mpc = a;
      else mpc = mpc + 4'd1;
      tick();
      s[5] = mReadFlag; s[4] = mWriteFlag; opc_seen = opcode;
      tick();
      s[3] = mReadFlag; s[2] = mWriteFlag; alu_seen = aluOut;
      tick();
      s[1] = mReadFlag; s[0] = mWriteFlag;
      check("rand_strobes", {26'd0, s}, {26'd0, rd, 1'b0, rd, wr, 2'b00});
      check("rand_opcode", opc_seen, op);
      check("rand_alu", alu_seen, macc);
      check("rand_acc", accOut, macc);
      check("rand_pc", instMemAddrBus, mpc);
    end
    for (int i = 0; i < 16; i++) check("rand_mem", dmem[i], mmem[i]);
  endtask

  initial begin
    int         wcount;
    logic       rany;
    logic [5:0] rpat;

    // Reset held low for three clocks.
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 8'h85;
      dmem[i] = 8'h00;
    end
    repeat (3) tick();
    check("rst_pc", instMemAddrBus, 4'h0);
    check("rst_acc", accOut, 8'h00);
    check("rst_opcode", opcode, 4'h0);
    check("rst_strobes", {mReadFlag, mWriteFlag}, 2'b00);
    check("rst_alu", aluOut, 8'h00);
    check("rst_daddr", dataMemAddrBus, 4'h0);

    // Table-driven programs.
    vq.push_back(mk("ldi5",     64'h85233343_00000000, 8'h00, 1,  8'h05, 4'h1));
    vq.push_back(mk("sta3",     64'h85233343_00000000, 8'h00, 2,  8'h05, 4'h2));
    vq.push_back(mk("add3",     64'h85233343_00000000, 8'h00, 3,  8'h0A, 4'h3));
    vq.push_back(mk("sub3",     64'h85233343_00000000, 8'h00, 4,  8'h05, 4'h4));
    vq.push_back(mk("addi",     64'h8F9F0000_00000000, 8'h00, 2,  8'h1E, 4'h2));
    vq.push_back(mk("not",      64'h8F9FA000_00000000, 8'h00, 3,  8'hE1, 4'h3));
    vq.push_back(mk("shl",      64'h8F9FA0B0_00000000, 8'h00, 4,  8'hC2, 4'h4));
    vq.push_back(mk("shr",      64'h8F9FA0B0_C0000000, 8'h00, 5,  8'h61, 4'h5));
    vq.push_back(mk("subneg",   64'h8A248544_00000000, 8'h00, 4,  8'hFB, 4'h4));
    vq.push_back(mk("jz_taken", 64'h80E60000_00000000, 8'h00, 2,  8'h00, 4'h6));
    vq.push_back(mk("jz_not",   64'h81E60000_00000000, 8'h00, 2,  8'h01, 4'h2));
    vq.push_back(mk("jmp5",     64'hD5000000_00000000, 8'h00, 1,  8'h00, 4'h5));
    vq.push_back(mk("jmp_wrap", 64'h0,                 8'hD0, 16, 8'h00, 4'h0));
    vq.push_back(mk("jmp_wrap1",64'h0,                 8'hD0, 17, 8'h00, 4'h1));
    vq.push_back(mk("seq_wrap", 64'h0,                 8'h00, 16, 8'h00, 4'h0));
    vq.push_back(mk("lda",      64'h8C238013_00000000, 8'h00, 4,  8'h0C, 4'h4));
    foreach (vq[i]) begin
      start(vq[i].prog, vq[i].last);
      repeat (3 * vq[i].n) tick();
      check({vq[i].name, "_acc"}, accOut, vq[i].acc);
      check({vq[i].name, "_pc"}, instMemAddrBus, vq[i].pc);
    end

    // STA write strobe: exactly one cycle, in EXECUTE of the second instruction.
    start(64'h85230000_00000000, 8'h00);
    wcount = 0;
    rany = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (mWriteFlag) wcount++;
      if (mReadFlag) rany = 1'b1;
      if (k == 5) begin
        check("sta_wr", mWriteFlag, 1'b1);
        check("sta_addr", dataMemAddrBus, 4'h3);
        check("sta_data", dataMemOutDataBus, 8'h05);
      end
    end
    check("sta_wcount", wcount, 1);
    check("sta_noread", rany, 1'b0);
    check("sta_mem", dmem[3], 8'h05);

    // LDA strobes followed by a NOP.
    start(64'h13000000_00000000, 8'h00);
    dmem[3] = 8'h5A;
    rpat = 6'b0;
    wcount = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rpat[6-k] = mReadFlag;
      if (mWriteFlag) wcount++;
      if (k == 1) check("lda_addr", dataMemAddrBus, 4'h3);
      if (k == 2) check("lda_alu", aluOut, 8'h5A);
      if (k == 3) check("lda_acc", accOut, 8'h5A);
    end
    check("lda_rd_pattern", rpat, 6'b110000);
    check("lda_nop_nowr", wcount, 0);

    // Reset asserted in EXECUTE of STA aborts the write.
    start(64'h85230000_00000000, 8'h00);
    repeat (5) tick();
    check("mid_wr_before", mWriteFlag, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_wr", mWriteFlag, 1'b0);
    check("mid_rd", mReadFlag, 1'b0);
    check("mid_acc", accOut, 8'h00);
    check("mid_pc", instMemAddrBus, 4'h0);
    check("mid_opcode", opcode, 4'h0);
    check("mid_alu", aluOut, 8'h00);
    check("mid_daddr", dataMemAddrBus, 4'h0);
    tick();
    check("mid_mem", dmem[3], 8'h00);
    reset = 1'b1;

    // HLT behaviour.
    start(64'h87F00000_00000000, 8'h00);
    repeat (6) tick();
`ifdef CPU_HALT_INSTR_EN
    check("hlt_pc", instMemAddrBus, 4'h1);
    check("hlt_acc", accOut, 8'h07);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("hlt_frozen", {instMemAddrBus, accOut, mReadFlag, mWriteFlag}, {4'h1, 8'h07, 2'b00});
    end
    reset = 1'b0;
    #1;
    check("hlt_rst_pc", instMemAddrBus, 4'h0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("hlt_restart_acc", accOut, 8'h07);
    check("hlt_restart_pc", instMemAddrBus, 4'h1);
`else
    check("hlt_nop_pc", instMemAddrBus, 4'h2);
    repeat (21) tick();
    check("hlt_nop_pc_adv", instMemAddrBus, 4'h9);
    check("hlt_nop_acc", accOut, 8'h07);
`endif

    // Randomized programs against the instruction-level model.
    run_random(40);
    run_random(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
